vit_layer_sequencer: RTL

VIT_LAYER_SEQUENCER -- requirements
Module: vit_layer_sequencer

---
 rtl/vit_pkg.sv | 14 +
 rtl/seq_watchdog.sv | 31 +++
 rtl/vit_layer_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/vit_pkg.sv
// Shared types for the ViT layer sequencer.
// Holds the sequencer state encoding.
package vit_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KICK,
        S_WAIT,
        S_NEXT,
        S_DONE,
        S_ERR
    } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Per-layer wait watchdog for the sequencer.
// Flags expiry on the last allowed wait cycle.
module seq_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int LV = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] LAST = CW'(LV);
    localparam bit ARMED = (TIMEOUT > 0);

    logic [CW-1:0] cnt;

    // wait-cycle counter, cleared at each kick
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = ARMED && (cnt == LAST);

endmodule

// File: rtl/vit_layer_sequencer.sv
// Runs NUM_LAYERS encoder passes over one activation buffer.
// Each pass kicks the block, waits for it, then loops.
module vit_layer_sequencer
    import vit_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SEQ_LEN    = 8,
    parameter int EMB_DIM    = 8,
    parameter int NUM_LAYERS = 4,
    parameter int TIMEOUT    = 4096,
    localparam int N  = SEQ_LEN * EMB_DIM,
    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] x_in      [N],
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] y_out     [N],
    output logic                  blk_start,
    input  logic                  blk_done,
    output logic [DATA_WIDTH-1:0] blk_x_in  [N],
    input  logic [DATA_WIDTH-1:0] blk_out   [N],
    output logic [LW-1:0]         layer_idx
);

    localparam logic [LW-1:0] LAST = LW'(NUM_LAYERS - 1);

    seq_state_t state;
    logic [DATA_WIDTH-1:0] act_buf [N];
    logic wd_clear;
    logic wd_en;
    logic wd_exp;

    assign wd_clear = (state == S_KICK);
    assign wd_en    = (state == S_WAIT);
    assign blk_x_in = act_buf;

    seq_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_en),
        .expired(wd_exp)
    );

    // sequencer FSM with registered status and strobe outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            layer_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            blk_start <= 1'b0;
            for (int i = 0; i < N; i++) begin
                act_buf[i] <= '0;
                y_out[i]   <= '0;
            end
        end else begin
            done      <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            blk_start <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        act_buf   <= x_in;
                        layer_idx <= '0;
                        blk_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_KICK;
                    end
                end
                S_KICK: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (blk_done) begin
                        act_buf <= blk_out;
                        state   <= S_NEXT;
                    end else if (wd_exp) begin
                        err   <= 1'b1;
                        state <= S_ERR;
                    end
                end
                S_NEXT: begin
                    if (layer_idx == LAST) begin
                        y_out     <= act_buf;
                        done      <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        layer_idx <= layer_idx + LW'(1);
                        blk_start <= 1'b1;
                        state     <= S_KICK;
                    end
                end
                S_DONE, S_ERR: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
